multicore_pixel_filter_master: RTL and testbench
================================================

// Module: multicore_pixel_filter_master
// PURPOSE
//  Avalon-MM master driving the 1024x32 single-port on-chip RAM slave (s1/s2).
//  Reads packed pixel words (4 x 8-bit, byte0 = bits[7:0]), applies a per-byte point filter,
//  writes the result back. Runs one job per start pulse, sequencing read -> capture -> write per word.
//  Sits directly upstream of the RAM; a core or host loads the job registers and starts it.
// PARAMETERS
//  ADDR_W   10   RAM word-address width; depth = 2**ADDR_W = 1024
//  DATA_W   32   RAM data width; fixed at 4 pixels of 8 bits
// PORTS
//  clk             in   1       system clock, the only clock
//  reset           in   1       synchronous, active-high
//  start           in   1       1-cycle job start; ignored while busy
//  src_base        in   10      first source word address
//  word_count      in   11      words to process, 0..1024
//  mode            in   2       0 copy, 1 invert, 2 threshold, 3 saturating brighten
//  param           in   8       threshold / brighten amount
//  busy            out  1       job in progress
//  done            out  1       1-cycle pulse at job end
//  ram_address     out  10      to RAM address
//  ram_chipselect  out  1       to RAM chipselect
//  ram_write       out  1       to RAM write
//  ram_byteenable  out  4       to RAM byteenable; 4'hF on every access
//  ram_writedata   out  32      to RAM writedata
//  ram_clken       out  1       to RAM clken; constant 1
//  ram_readdata    in   32      from RAM readdata (unregistered q, 1-cycle read latency)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, ram_chipselect, ram_write = 0; ram_address, ram_writedata = 0.
//  Job registers (src_base, word_count, mode, param) latched on accepted start; inputs then don't-care.
//  FSM: IDLE -start&count!=0-> READ; IDLE -start&count==0-> DONE (no RAM access).
//   READ : cs=1, write=0, address=src_base+idx                       -> WAIT
//   WAIT : cs=0; ram_readdata valid this cycle, captured at edge       -> WRITE
//   WRITE: cs=1, write=1, address=dest addr, writedata=f(captured)    -> READ if idx+1<count, else DONE
//   DONE : done=1 for exactly one cycle, cs=0                         -> IDLE
//  busy = 1 in READ/WAIT/WRITE/DONE, 0 in IDLE. Cycle cost: 3N+1 from start edge to done pulse.
//  Address arithmetic modulo 1024: src_base+idx wraps 1023 -> 0. idx is 11 bits, counts 0..count-1.
//  Per-byte f(p): copy p; invert 255-p; threshold (p>=param)?255:0; brighten min(p+param,255) (9-bit sum).
//  start while busy: dropped, no effect on running job. start and reset same cycle: reset wins.
//  reset mid-job: next cycle IDLE, all outputs at reset value; words already written stay written.
//  ram_chipselect never asserted in WAIT, IDLE, DONE; at most one RAM access per cycle.
// CONFIGURATION
//  PIXEL_FILTER_DEST_EN defined: adds input port dst_base [9:0], latched on start;
//   WRITE address = dst_base+idx (mod 1024); overlapping src/dst regions not checked.
//  Not defined: no dst_base port; in-place, WRITE address = src_base+idx.
// TESTING
//  RAM preloaded [5]=32'h00FF8010, mode=1, src_base=5, count=1 -> [5]=32'hFF007FEF, done at cycle 4.
//  mode=2, param=8'h80, word 32'h7F80FF00 -> 32'h00FFFF00; mode=3 param=8'h20 word 32'hF0E01000 -> 32'hFFFF3020.
//  src_base=1022, count=4, mode=0 -> accesses 1022,1023,0,1; data unchanged; done 13 cycles after start.
//  count=0 -> no chipselect ever, done pulses cycle after start; second start while busy -> ignored, one done.
//  reset asserted in WAIT of word 2 of 8 -> word 0,1 filtered, word 2+ untouched, busy=0 next cycle.
//  PIXEL_FILTER_DEST_EN build: src 0, dst 512, count 16, mode 1 -> [512..527]=~[0..15], [0..15] unchanged.

Source files
------------

// File: rtl/multicore_pixel_filter_master.sv
// Avalon-MM master that filters a block of packed 4x8-bit pixel words in the on-chip RAM.
// Optional `PIXEL_FILTER_DEST_EN adds a dst_base port so results can land in a separate region.
module multicore_pixel_filter_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
`ifdef PIXEL_FILTER_DEST_EN
    input  logic [ADDR_W-1:0] dst_base,
`endif
    input  logic [ADDR_W:0]   word_count,
    input  logic [1:0]        mode,
    input  logic [7:0]        param,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam int NPIX = DATA_W / 8;

    localparam logic [1:0] MODE_COPY   = 2'd0;
    localparam logic [1:0] MODE_INVERT = 2'd1;
    localparam logic [1:0] MODE_THRESH = 2'd2;
    localparam logic [1:0] MODE_BRIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] src_base_reg;
    logic [ADDR_W-1:0] dst_base_reg;
    logic [ADDR_W:0]   count_reg;
    logic [1:0]        mode_reg;
    logic [7:0]        param_reg;
    logic [ADDR_W:0]   idx_reg;
    logic [ADDR_W:0]   idx_next;
    logic [ADDR_W-1:0] src_addr_next;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] filtered_word;

    assign ram_byteenable = 4'hF;
    assign ram_clken      = 1'b1;

    // Address sums are ADDR_W bits wide so they wrap modulo the RAM depth for free.
    assign idx_next      = idx_reg + (ADDR_W + 1)'(1);
    assign src_addr_next = src_base_reg + idx_next[ADDR_W-1:0];
    assign dst_addr      = dst_base_reg + idx_reg[ADDR_W-1:0];

    // Filter operates straight off the RAM q so the result is registered at the WAIT edge.
    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_pix
            logic [7:0] pix;
            logic [8:0] sum;
            logic [7:0] pix_out;

            assign pix = ram_readdata[gi*8 +: 8];
            assign sum = {1'b0, pix} + {1'b0, param_reg};

            always_comb begin
                pix_out = pix;
                case (mode_reg)
                    MODE_COPY:   pix_out = pix;
                    MODE_INVERT: pix_out = ~pix;
                    MODE_THRESH: pix_out = (pix >= param_reg) ? 8'hFF : 8'h00;
                    MODE_BRIGHT: pix_out = sum[8] ? 8'hFF : sum[7:0];
                    default:     pix_out = pix;
                endcase
            end

            assign filtered_word[gi*8 +: 8] = pix_out;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_address    <= '0;
            ram_writedata  <= '0;
            src_base_reg   <= '0;
            dst_base_reg   <= '0;
            count_reg      <= '0;
            mode_reg       <= MODE_COPY;
            param_reg      <= '0;
            idx_reg        <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        src_base_reg <= src_base;
`ifdef PIXEL_FILTER_DEST_EN
                        dst_base_reg <= dst_base;
`else
                        dst_base_reg <= src_base;
`endif
                        count_reg    <= word_count;
                        mode_reg     <= mode;
                        param_reg    <= param;
                        idx_reg      <= '0;
                        busy         <= 1'b1;
                        if (word_count != '0) begin
                            state_reg      <= S_READ;
                            ram_chipselect <= 1'b1;
                            ram_write      <= 1'b0;
                            ram_address    <= src_base;
                        end else begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state_reg      <= S_WAIT;
                    ram_chipselect <= 1'b0;
                end
                S_WAIT: begin
                    state_reg      <= S_WRITE;
                    ram_chipselect <= 1'b1;
                    ram_write      <= 1'b1;
                    ram_address    <= dst_addr;
                    ram_writedata  <= filtered_word;
                end
                S_WRITE: begin
                    ram_write <= 1'b0;
                    if (idx_next < count_reg) begin
                        idx_reg        <= idx_next;
                        state_reg      <= S_READ;
                        ram_chipselect <= 1'b1;
                        ram_address    <= src_addr_next;
                    end else begin
                        state_reg      <= S_DONE;
                        ram_chipselect <= 1'b0;
                        done           <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg      <= S_IDLE;
                    busy           <= 1'b0;
                    ram_chipselect <= 1'b0;
                    ram_write      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicore_pixel_filter_master.sv
// Directed bench for multicore_pixel_filter_master with a behavioural 1024x32 RAM slave.
// Define PIXEL_FILTER_DEST_EN to also exercise the separate-destination build.
module tb_multicore_pixel_filter_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  src_base;
    logic [10:0] word_count;
    logic [1:0]  mode;
    logic [7:0]  param;
    logic        busy;
    logic        done;
    logic [9:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;
`ifdef PIXEL_FILTER_DEST_EN
    logic [9:0]  dst_base;
    logic        dst_redirect;
    logic [9:0]  dst_val;
`endif

    logic [31:0] mem [0:1023];
    logic [10:0] acc_log [$];
    int          proto_err;
    int          n_vec;
    int          n_fail;

    always #5 clk = ~clk;

    multicore_pixel_filter_master dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src_base       (src_base),
`ifdef PIXEL_FILTER_DEST_EN
        .dst_base       (dst_base),
`endif
        .word_count     (word_count),
        .mode           (mode),
        .param          (param),
        .busy           (busy),
        .done           (done),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_byteenable (ram_byteenable),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    // RAM slave: registered address, q valid the cycle after a read access.
    always @(posedge clk) begin
        if (ram_chipselect) begin
            acc_log.push_back({ram_write, ram_address});
            if (ram_byteenable != 4'hF || ram_clken != 1'b1 || !busy)
                proto_err = proto_err + 1;
            if (ram_write)
                mem[ram_address] = ram_writedata;
            else
                ram_readdata <= mem[ram_address];
        end
    end

    typedef struct {
        logic [9:0]  src;
        logic [1:0]  mode;
        logic [7:0]  param;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [9:0] s, input logic [10:0] n, input logic [1:0] m, input logic [7:0] p);
        @(negedge clk);
        src_base   = s;
        word_count = n;
        mode       = m;
        param      = p;
`ifdef PIXEL_FILTER_DEST_EN
        dst_base   = dst_redirect ? dst_val : s;
`endif
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Returns the cycle (start edge = 0) in which done is high.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat = lat + 1;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int extra_done;
        logic [31:0] pat;
        n_vec      = 0;
        n_fail     = 0;
        proto_err  = 0;
        reset      = 1'b1;
        start      = 1'b0;
        src_base   = '0;
        word_count = '0;
        mode       = '0;
        param      = '0;
`ifdef PIXEL_FILTER_DEST_EN
        dst_base     = '0;
        dst_redirect = 1'b0;
        dst_val      = '0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | 32'(i);

        vecs[0] = '{10'd5,    2'd1, 8'h00, 32'h00FF8010, 32'hFF007FEF};
        vecs[1] = '{10'd6,    2'd2, 8'h80, 32'h7F80FF00, 32'h00FFFF00};
        vecs[2] = '{10'd7,    2'd3, 8'h20, 32'hF0E01000, 32'hFFFF3020};
        vecs[3] = '{10'd8,    2'd0, 8'h55, 32'h12345678, 32'h12345678};
        vecs[4] = '{10'd9,    2'd2, 8'h00, 32'h00010203, 32'hFFFFFFFF};
        vecs[5] = '{10'd10,   2'd3, 8'hFE, 32'h00000100, 32'hFEFEFFFE};
        vecs[6] = '{10'd1023, 2'd1, 8'h00, 32'h00000000, 32'hFFFFFFFF};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cs",   32'(ram_chipselect), 32'd0);
        check("rst_wr",   32'(ram_write), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_wdat", ram_writedata, 32'd0);
        // start and reset together: reset wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_vs_start_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single-word table
        for (int v = 0; v < 7; v++) begin
            mem[vecs[v].src] = vecs[v].din;
            launch(vecs[v].src, 11'd1, vecs[v].mode, vecs[v].param);
            wait_done(lat);
            check($sformatf("vec%0d_data", v), mem[vecs[v].src], vecs[v].dout);
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'd4);
            $display("vec %0d: mode %0d param %h in %h out %h done@%0d",
                     v, vecs[v].mode, vecs[v].param, vecs[v].din, mem[vecs[v].src], lat);
            @(negedge clk);
        end

        // Wrap-around copy: 1022,1023,0,1
        acc_log.delete();
        launch(10'd1022, 11'd4, 2'd0, 8'h00);
        wait_done(lat);
        check("wrap_lat", 32'(lat), 32'd13);
        check("wrap_nacc", 32'(acc_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < acc_log.size(); k++) begin
            pat = 32'({(k % 2 == 1), 10'((1022 + k / 2) % 1024)});
            check($sformatf("wrap_acc%0d", k), 32'(acc_log[k]), pat);
        end
        check("wrap_d1023", mem[1023], 32'hFFFFFFFF);
        check("wrap_d0", mem[0], 32'hA5000000);
        $display("wrap job: %0d accesses, done@%0d", acc_log.size(), lat);
        @(negedge clk);

        // Zero-length job
        acc_log.delete();
        launch(10'd50, 11'd0, 2'd1, 8'h00);
        wait_done(lat);
        check("zero_lat", 32'(lat), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("zero_nacc", 32'(acc_log.size()), 32'd0);
        check("zero_idle", 32'(busy), 32'd0);
        $display("zero job: done@%0d", lat);

        // Second start while busy is dropped
        launch(10'd200, 11'd2, 2'd1, 8'h00);
        @(negedge clk);
        src_base = 10'd300; word_count = 11'd5; mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        wait_done(lat);
        check("busy_start_lat", 32'(lat + 2), 32'd7);
        extra_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("busy_start_dones", 32'(extra_done), 32'd0);
        check("busy_start_w0", mem[200], ~(32'hA5000000 | 32'd200));
        check("busy_start_w1", mem[201], ~(32'hA5000000 | 32'd201));
        $display("busy-start job: done@%0d, extra dones %0d", lat + 2, extra_done);

        // Reset in WAIT of word 2 of an 8-word invert job
        launch(10'd100, 11'd8, 2'd1, 8'h00);
        repeat (7) @(negedge clk);
        check("midrst_wait_busy", 32'(busy), 32'd1);
        check("midrst_wait_cs", 32'(ram_chipselect), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cs", 32'(ram_chipselect), 32'd0);
        check("midrst_addr", 32'(ram_address), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            pat = 32'hA5000000 | 32'(100 + k);
            check($sformatf("midrst_w%0d", k), mem[100 + k], (k < 2) ? ~pat : pat);
        end
        $display("mid-job reset: words 0..1 filtered, 2..7 untouched");

`ifdef PIXEL_FILTER_DEST_EN
        dst_redirect = 1'b1;
        dst_val      = 10'd512;
        for (int k = 0; k < 16; k++) mem[k] = 32'h3C000000 | 32'(k * 7);
        launch(10'd0, 11'd16, 2'd1, 8'h00);
        wait_done(lat);
        check("dest_lat", 32'(lat), 32'd49);
        for (int k = 0; k < 16; k++) begin
            pat = 32'h3C000000 | 32'(k * 7);
            check($sformatf("dest_dst%0d", k), mem[512 + k], ~pat);
            check($sformatf("dest_src%0d", k), mem[k], pat);
        end
        dst_redirect = 1'b0;
        $display("dest job: 16 words to 512, done@%0d", lat);
        @(negedge clk);
`endif

        check("protocol_errors", 32'(proto_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
